// File: rtl/inst_loader.sv
// inst_loader: framed UART program loader. Parses a 4-byte little-endian word
// count, packs N words of payload bytes into instruction memory, then checks a
// one-byte additive checksum over the payload and reports done or error.
module inst_loader #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned WORD_BYTES = 4,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [WORD_BYTES*8-1:0] mem_data,
  output logic                    mem_we,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH:0]     words_loaded
);

  localparam int unsigned WordW    = WORD_BYTES * 8;
  localparam logic [2:0]  LastByte = 3'(WORD_BYTES - 1);
  // Largest legal word count is 2^ADDR_WIDTH; 33 bits holds it next to a 32-bit header.
  localparam logic [32:0] MaxWords = 33'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StLen, StData, StSum, StDone, StErr} state_e;

  state_e                state_q;
  logic [2:0]            byte_cnt_q;
  logic [31:0]           len_q;
  logic [ADDR_WIDTH-1:0] word_idx_q;
  logic [7:0]            sum_q;
  logic [WordW-1:0]      word_q;

  logic [31:0]           len_next;
  logic [2:0]            byte_pos;
  logic [WordW-1:0]      word_next;
  logic                  last_word;

  // Header shift, byte placement within the word, and last-word detection.
  always_comb begin
    // Little-endian header: each new byte enters at the top and shifts down.
    len_next  = {rx_data, len_q[31:8]};
    byte_pos  = BIG_ENDIAN ? (LastByte - byte_cnt_q) : byte_cnt_q;
    word_next = word_q;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (byte_pos == 3'(i)) begin
        word_next[i*8 +: 8] = rx_data;
      end
    end
    // len_q is known to fit in ADDR_WIDTH+1 bits once DATA is reached.
    last_word = ((words_loaded + (ADDR_WIDTH+1)'(1)) == len_q[ADDR_WIDTH:0]);
  end

  // Frame parser FSM with all outputs registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      sum_q        <= '0;
      word_q       <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        // start outranks a simultaneous byte, which is dropped.
        state_q      <= StLen;
        byte_cnt_q   <= '0;
        len_q        <= '0;
        word_idx_q   <= '0;
        sum_q        <= '0;
        words_loaded <= '0;
        busy         <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
      end else if (rx_valid) begin
        case (state_q)
          StLen: begin
            len_q <= len_next;
            if (byte_cnt_q == 3'd3) begin
              byte_cnt_q <= '0;
              if ({1'b0, len_next} > MaxWords) begin
                state_q <= StErr;
                busy    <= 1'b0;
                error   <= 1'b1;
              end else if (len_next == '0) begin
                state_q <= StSum;
              end else begin
                state_q <= StData;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
          StData: begin
            word_q <= word_next;
            sum_q  <= sum_q + rx_data;
            if (byte_cnt_q == LastByte) begin
              byte_cnt_q   <= '0;
              mem_we       <= 1'b1;
              mem_addr     <= word_idx_q;
              mem_data     <= word_next;
              word_idx_q   <= word_idx_q + ADDR_WIDTH'(1);
              words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
              if (last_word) begin
                state_q <= StSum;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
          StSum: begin
            busy <= 1'b0;
            if (rx_data == sum_q) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StErr;
              error   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: two instances (17-bit/4-byte little-endian and
// 4-bit/2-byte big-endian) driven by directed and random frames, compared
// against a frame-level reference model.
`timescale 1ns/1ps
module tb_inst_loader;

  localparam int A0 = 17;
  localparam int W0 = 4;
  localparam int A1 = 4;
  localparam int W1 = 2;

  localparam int KWe = 0, KBusy = 1, KDone = 2, KErr = 3, KWords = 4, KAddr = 5, KData = 6;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic          s0_start = 1'b0, s0_valid = 1'b0;
  logic [7:0]    s0_data = 8'h00;
  logic [A0-1:0] m0_addr;
  logic [W0*8-1:0] m0_data;
  logic          m0_we, m0_busy, m0_done, m0_error;
  logic [A0:0]   m0_words;

  logic          s1_start = 1'b0, s1_valid = 1'b0;
  logic [7:0]    s1_data = 8'h00;
  logic [A1-1:0] m1_addr;
  logic [W1*8-1:0] m1_data;
  logic          m1_we, m1_busy, m1_done, m1_error;
  logic [A1:0]   m1_words;

  inst_loader #(.ADDR_WIDTH(A0), .WORD_BYTES(W0), .BIG_ENDIAN(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .start(s0_start), .rx_data(s0_data), .rx_valid(s0_valid),
    .mem_addr(m0_addr), .mem_data(m0_data), .mem_we(m0_we), .busy(m0_busy),
    .done(m0_done), .error(m0_error), .words_loaded(m0_words)
  );

  inst_loader #(.ADDR_WIDTH(A1), .WORD_BYTES(W1), .BIG_ENDIAN(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .start(s1_start), .rx_data(s1_data), .rx_valid(s1_valid),
    .mem_addr(m1_addr), .mem_data(m1_data), .mem_we(m1_we), .busy(m1_busy),
    .done(m1_done), .error(m1_error), .words_loaded(m1_words)
  );

  int passes = 0;
  int total  = 0;

  logic [7:0]  frame[$];
  logic [95:0] exp_wr[$];
  logic [95:0] wq0[$];
  logic [95:0] wq1[$];
  int          exp_n, decide_idx;
  bit          exp_done, exp_err, exp_over;

  // Record every write strobe seen, sampled mid-cycle.
  always @(negedge CLK) begin
    if (m0_we === 1'b1) wq0.push_back({32'(m0_addr), 64'(m0_data)});
    if (m1_we === 1'b1) wq1.push_back({32'(m1_addr), 64'(m1_data)});
  end

  task automatic check(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
    total++;
    assert (obs_v === exp_v) passes++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs_v, exp_v);
  endtask

  function automatic logic [63:0] obs(input int d, input int k);
    if (d == 0) begin
      case (k)
        KWe:     return 64'(m0_we);
        KBusy:   return 64'(m0_busy);
        KDone:   return 64'(m0_done);
        KErr:    return 64'(m0_error);
        KWords:  return 64'(m0_words);
        KAddr:   return 64'(m0_addr);
        default: return 64'(m0_data);
      endcase
    end else begin
      case (k)
        KWe:     return 64'(m1_we);
        KBusy:   return 64'(m1_busy);
        KDone:   return 64'(m1_done);
        KErr:    return 64'(m1_error);
        KWords:  return 64'(m1_words);
        KAddr:   return 64'(m1_addr);
        default: return 64'(m1_data);
      endcase
    end
  endfunction

  task automatic drive(input int d, input logic st, input logic v, input logic [7:0] b);
    if (d == 0) begin s0_start = st; s0_valid = v; s0_data = b; end
    else begin s1_start = st; s1_valid = v; s1_data = b; end
  endtask

  // One clock with the given inputs; returns 1ns after the capturing edge.
  task automatic step(input int d, input logic st, input logic v, input logic [7:0] b);
    drive(d, st, v, b);
    @(posedge CLK);
    #1;
    drive(d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_reset_vals(input int d);
    check("rst_we", obs(d, KWe), 0);
    check("rst_busy", obs(d, KBusy), 0);
    check("rst_done", obs(d, KDone), 0);
    check("rst_error", obs(d, KErr), 0);
    check("rst_words", obs(d, KWords), 0);
    check("rst_addr", obs(d, KAddr), 0);
    check("rst_data", obs(d, KData), 0);
  endtask

  // Reference model: interprets the whole frame from the format rules.
  task automatic model(input int d);
    int a, wb, pos;
    bit be;
    longint unsigned n;
    logic [7:0] s;
    logic [63:0] w;
    a  = (d == 0) ? A0 : A1;
    wb = (d == 0) ? W0 : W1;
    be = (d == 1);
    exp_wr.delete();
    s = 8'h00;
    n = 0;
    for (int k = 0; k < 4; k++) n += longint'(frame[k]) << (8 * k);
    if (n > (longint'(1) << a)) begin
      exp_over = 1; exp_err = 1; exp_done = 0; exp_n = 0; decide_idx = 3;
      return;
    end
    exp_over = 0;
    exp_n = int'(n);
    for (int wi = 0; wi < exp_n; wi++) begin
      w = 64'h0;
      for (int k = 0; k < wb; k++) begin
        s += frame[4 + wi*wb + k];
        pos = be ? (wb - 1 - k) : k;
        w |= 64'(frame[4 + wi*wb + k]) << (8 * pos);
      end
      exp_wr.push_back({32'(wi), w});
    end
    decide_idx = 4 + exp_n * wb;
    exp_done = (frame[decide_idx] == s);
    exp_err  = !exp_done;
  endtask

  task automatic build_frame(input int d, input int n, input bit bad);
    int wb;
    logic [7:0] s, b;
    wb = (d == 0) ? W0 : W1;
    frame.delete();
    s = 8'h00;
    for (int k = 0; k < 4; k++) frame.push_back(8'((n >> (8*k)) & 255));
    for (int i = 0; i < n * wb; i++) begin
      b = 8'($urandom_range(0, 255));
      s += b;
      frame.push_back(b);
    end
    frame.push_back(bad ? 8'(s + 8'($urandom_range(1, 255))) : s);
  endtask

  // Start a load, stream the frame, and compare timing, status and writes.
  task automatic run_frame(input int d, input int gapmax, input bit junk);
    int wb, n_wr, g;
    bit we_exp;
    logic [95:0] got;
    wb = (d == 0) ? W0 : W1;
    model(d);
    if (d == 0) wq0.delete(); else wq1.delete();
    step(d, 1'b1, junk, 8'($urandom_range(0, 255)));
    check("start_busy", obs(d, KBusy), 1);
    check("start_done", obs(d, KDone), 0);
    check("start_error", obs(d, KErr), 0);
    check("start_words", obs(d, KWords), 0);
    for (int i = 0; i < frame.size(); i++) begin
      step(d, 1'b0, 1'b1, frame[i]);
      we_exp = !exp_over && i >= 4 && i < 4 + exp_n*wb && ((i - 4) % wb) == wb - 1;
      check("we_timing", obs(d, KWe), 64'(we_exp));
      if (i == decide_idx) begin
        check("decide_busy", obs(d, KBusy), 0);
        check("decide_done", obs(d, KDone), 64'(exp_done));
        check("decide_error", obs(d, KErr), 64'(exp_err));
      end
      g = int'($urandom_range(0, gapmax));
      repeat (g) begin @(posedge CLK); #1; end
    end
    repeat (2) begin @(posedge CLK); #1; end
    n_wr = (d == 0) ? wq0.size() : wq1.size();
    check("write_count", 64'(n_wr), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < n_wr; i++) begin
      got = (d == 0) ? wq0[i] : wq1[i];
      check("write_addr", 64'(got[95:64]), 64'(exp_wr[i][95:64]));
      check("write_data", got[63:0], exp_wr[i][63:0]);
    end
    if (exp_wr.size() > 0) begin
      check("hold_addr", obs(d, KAddr), 64'(exp_wr[exp_wr.size()-1][95:64]));
      check("hold_data", obs(d, KData), exp_wr[exp_wr.size()-1][63:0]);
    end
    check("end_done", obs(d, KDone), 64'(exp_done));
    check("end_error", obs(d, KErr), 64'(exp_err));
    check("end_busy", obs(d, KBusy), 0);
    check("end_words", obs(d, KWords), 64'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz;
    // Reset values while RST is held.
    repeat (2) @(posedge CLK);
    #1;
    check_reset_vals(0);
    check_reset_vals(1);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Two-word little-endian image; payload sums to 0x4C mod 256.
    frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C, 8'h11, 8'h22};
    run_frame(0, 0, 1'b0);
    check("le_w0", (wq0.size() > 0) ? wq0[0] : 96'h0, {32'd0, 64'h12345678});
    check("le_w1", (wq0.size() > 1) ? wq0[1] : 96'h0, {32'd1, 64'hDEADBEEF});
    check("le_done", obs(0, KDone), 1);

    // Same payload, wrong checksum: words still written, error reported.
    frame[12] = 8'h6B;
    run_frame(0, 1, 1'b0);
    check("bad_sum_error", obs(0, KErr), 1);
    check("bad_sum_writes", 64'(wq0.size()), 2);

    // Empty image, with a trailing byte that must be ignored.
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};
    run_frame(0, 2, 1'b0);
    check("empty_done", obs(0, KDone), 1);

    // Oversize on the 4-bit instance: N=17 > 16, later bytes ignored.
    frame = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(1, 0, 1'b0);
    check("over_error", obs(1, KErr), 1);
    check("over_nowrite", 64'(wq1.size()), 0);

    // Oversize on the 17-bit instance: N = 2^17 + 1.
    frame = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h00};
    run_frame(0, 0, 1'b0);

    // Largest legal image on the 4-bit instance: N = 16.
    build_frame(1, 16, 1'b0);
    run_frame(1, 0, 1'b0);
    check("max_words", obs(1, KWords), 16);

    // Big-endian 2-byte words, back-to-back bytes.
    frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'h78};
    run_frame(1, 0, 1'b0);
    check("be_w0", (wq1.size() > 0) ? wq1[0] : 96'h0, {32'd0, 64'hABCD});
    check("be_done", obs(1, KDone), 1);

    // start with a simultaneous byte: the byte must be dropped.
    build_frame(0, 2, 1'b0);
    run_frame(0, 0, 1'b1);

    // Restart after one word and half of the next.
    step(0, 1'b1, 1'b0, 8'h00);
    frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    foreach (frame[i]) step(0, 1'b0, 1'b1, frame[i]);
    check("restart_pre_words", obs(0, KWords), 1);
    build_frame(0, 1, 1'b0);
    run_frame(0, 0, 1'b0);

    // Asynchronous reset between the bytes of a word.
    wq0.delete();
    step(0, 1'b1, 1'b0, 8'h00);
    frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    foreach (frame[i]) step(0, 1'b0, 1'b1, frame[i]);
    check("prereset_words", obs(0, KWords), 1);
    check("prereset_data", obs(0, KData), 64'hD4C3B2A1);
    sz = wq0.size();
    #3;
    RST = 1'b1;
    #1;
    check_reset_vals(0);
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    step(0, 1'b0, 1'b1, 8'h17);
    step(0, 1'b0, 1'b1, 8'h28);
    repeat (3) begin @(posedge CLK); #1; end
    check("postreset_nowrite", 64'(wq0.size()), 64'(sz));
    check("postreset_words", obs(0, KWords), 0);
    check("postreset_busy", obs(0, KBusy), 0);

    // Random frames on both instances.
    for (int it = 0; it < 12; it++) begin
      int d, n;
      bit bad;
      d   = it % 2;
      n   = int'($urandom_range(0, (d == 0) ? 4 : 16));
      bad = ($urandom_range(0, 3) == 0);
      build_frame(d, n, bad);
      if ($urandom_range(0, 1) == 1) frame.push_back(8'($urandom_range(0, 255)));
      run_frame(d, 2, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
